alu_issue_stage: RTL and testbench

//  Upstream operand/issue stage for the N-bit ALU: accepts one instruction per valid/ready

---
 rtl/alu_pkg.sv | 8 +
 rtl/alu_regfile.sv | 27 ++
 rtl/alu_issue_stage.sv | 79 +++++++
 tb/tb_alu_issue_stage.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode width, legal opcode limit and issue-stage state encoding shared with the ALU
package alu_pkg;
  localparam int OPC_W = 4;
  localparam logic [OPC_W-1:0] MAX_OP = 4'd8;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] WB = 2'd2;
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREG x N register file, two async read ports, one write port (writeback wins over load)
module alu_regfile #(
  parameter int N = 32,
  parameter int NREG = 8,
  parameter int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [N-1:0]  wb_wdata,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [N-1:0]  ld_wdata,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  output logic [N-1:0]  rdata_a,
  output logic [N-1:0]  rdata_b
);
  logic [NREG-1:0][N-1:0] rf;
  assign rdata_a = rf[ra];
  assign rdata_b = rf[rb];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rf <= '0;
    else if (wb_we) rf[wb_addr] <= wb_wdata;
    else if (ld_we) rf[ld_addr] <= ld_wdata;
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: issues one instruction per 3 cycles to the ALU and writes its result back
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int N = 32,
  parameter int NREG = 8,
  parameter int AW = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [OPC_W-1:0] instr_opcode,
  input  logic [AW-1:0]    instr_rd,
  input  logic [AW-1:0]    instr_rs1,
  input  logic [AW-1:0]    instr_rs2,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [AW-1:0]    ld_addr,
  input  logic [N-1:0]     ld_data,
  output logic [OPC_W-1:0] alu_opcode,
  output logic [N-1:0]     alu_op_a,
  output logic [N-1:0]     alu_op_b,
  input  logic [N-1:0]     alu_result,
  output logic             wb_valid,
  output logic [AW-1:0]    wb_rd,
  output logic [N-1:0]     wb_data,
  output logic             err_illegal
);
  logic [1:0] state;
  logic [AW-1:0] rd_q;
  logic [N-1:0] rdata_a, rdata_b;
  logic accept, legal;
  assign instr_ready = rst_n && state == IDLE;
  assign ld_ready = rst_n && state != WB;
  assign accept = instr_valid && instr_ready;
  assign legal = instr_opcode <= MAX_OP;
  alu_regfile #(.N(N), .NREG(NREG), .AW(AW)) u_rf (
    .clk(clk),
    .rst_n(rst_n),
    .wb_we(state == WB),
    .wb_addr(rd_q),
    .wb_wdata(alu_result),
    .ld_we(ld_valid && ld_ready),
    .ld_addr(ld_addr),
    .ld_wdata(ld_data),
    .ra(instr_rs1),
    .rb(instr_rs2),
    .rdata_a(rdata_a),
    .rdata_b(rdata_b)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rd_q <= '0;
      alu_opcode <= '0;
      alu_op_a <= '0;
      alu_op_b <= '0;
      wb_valid <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
      err_illegal <= 1'b0;
    end else begin
      state <= state == IDLE ? (accept && legal ? EXEC : IDLE) : (state == EXEC ? WB : IDLE);
      err_illegal <= accept && !legal;
      wb_valid <= state == WB;
      if (state == WB) begin
        wb_rd <= rd_q;
        wb_data <= alu_result;
      end
      // operands are sampled before any same-cycle load lands
      if (accept && legal) begin
        rd_q <= instr_rd;
        alu_opcode <= instr_opcode;
        alu_op_a <= rdata_a;
        alu_op_b <= rdata_b;
      end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vectors against a simple ALU model hooked to the issue stage
module tb_alu_issue_stage;
  logic clk = 1'b0, rst_n = 1'b0;
  logic instr_valid = 1'b0, instr_ready;
  logic [3:0] instr_opcode = '0;
  logic [2:0] instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
  logic ld_valid = 1'b0, ld_ready;
  logic [2:0] ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [3:0] alu_opcode;
  logic [31:0] alu_op_a, alu_op_b, alu_result, wb_data;
  logic wb_valid, err_illegal;
  logic [2:0] wb_rd;
  int n_cmp = 0, n_err = 0;
  typedef struct {
    logic [3:0] op;
    logic [2:0] rd;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[9];
  always #5 clk = ~clk;
  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_opcode(instr_opcode),
    .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_opcode(alu_opcode), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .err_illegal(err_illegal)
  );
  function automatic logic [31:0] alu_model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return a * b;
      4'd8: return {31'd0, a < b};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction
  assign alu_result = alu_model(alu_opcode, alu_op_a, alu_op_b);
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic ld(input logic [2:0] a, input logic [31:0] d);
    ld_valid = 1'b1;
    ld_addr = a;
    ld_data = d;
    chk("ld_ready", 32'(ld_ready), 32'd1);
    @(negedge clk);
    ld_valid = 1'b0;
  endtask
  // called at a negedge in IDLE; returns at the negedge of the wb_valid cycle
  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [31:0] ea, input logic [31:0] eb,
                       input logic [31:0] ew, input string nm);
    chk({nm, ".ready_idle"}, 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    instr_opcode = op;
    instr_rd = rd;
    instr_rs1 = rs1;
    instr_rs2 = rs2;
    @(negedge clk);
    instr_valid = 1'b0;
    chk({nm, ".opcode"}, 32'(alu_opcode), 32'(op));
    chk({nm, ".op_a"}, alu_op_a, ea);
    chk({nm, ".op_b"}, alu_op_b, eb);
    chk({nm, ".ready_exec"}, 32'(instr_ready), 32'd0);
    chk({nm, ".wb_exec"}, 32'(wb_valid), 32'd0);
    @(negedge clk);
    chk({nm, ".ready_wb"}, 32'(instr_ready), 32'd0);
    chk({nm, ".wb_early"}, 32'(wb_valid), 32'd0);
    @(negedge clk);
    chk({nm, ".wb_valid"}, 32'(wb_valid), 32'd1);
    chk({nm, ".wb_rd"}, 32'(wb_rd), 32'(rd));
    chk({nm, ".wb_data"}, wb_data, ew);
  endtask
  initial begin
    tbl[0] = '{4'd0, 3'd4, 32'd5};
    tbl[1] = '{4'd1, 3'd5, 32'hFFFF_FFFF};
    tbl[2] = '{4'd2, 3'd6, 32'd2};
    tbl[3] = '{4'd3, 3'd7, 32'd3};
    tbl[4] = '{4'd4, 3'd4, 32'd1};
    tbl[5] = '{4'd5, 3'd5, 32'd16};
    tbl[6] = '{4'd6, 3'd6, 32'd0};
    tbl[7] = '{4'd7, 3'd7, 32'd6};
    tbl[8] = '{4'd8, 3'd4, 32'd1};
    repeat (3) @(negedge clk);
    chk("rst.instr_ready", 32'(instr_ready), 32'd0);
    chk("rst.ld_ready", 32'(ld_ready), 32'd0);
    chk("rst.wb_valid", 32'(wb_valid), 32'd0);
    chk("rst.err", 32'(err_illegal), 32'd0);
    chk("rst.opcode", 32'(alu_opcode), 32'd0);
    chk("rst.op_a", alu_op_a, 32'd0);
    chk("rst.op_b", alu_op_b, 32'd0);
    chk("rst.wb_rd", 32'(wb_rd), 32'd0);
    chk("rst.wb_data", wb_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel.instr_ready", 32'(instr_ready), 32'd1);
    ld(3'd1, 32'd2);
    ld(3'd2, 32'd3);
    issue(4'd0, 3'd3, 3'd1, 3'd2, 32'd2, 32'd3, 32'd5, "basic");
    issue(4'd0, 3'd4, 3'd3, 3'd3, 32'd5, 32'd5, 32'd10, "readback");
    for (int i = 0; i < 9; i++)
      issue(tbl[i].op, tbl[i].rd, 3'd1, 3'd2, 32'd2, 32'd3, tbl[i].exp, $sformatf("sweep%0d", i));
    instr_valid = 1'b1;
    instr_opcode = 4'd9;
    instr_rd = 3'd5;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("ill.err", 32'(err_illegal), 32'd1);
    chk("ill.ready", 32'(instr_ready), 32'd1);
    chk("ill.opcode", 32'(alu_opcode), 32'd8);
    chk("ill.op_a", alu_op_a, 32'd2);
    chk("ill.wb", 32'(wb_valid), 32'd0);
    @(negedge clk);
    chk("ill.err_pulse", 32'(err_illegal), 32'd0);
    chk("ill.wb2", 32'(wb_valid), 32'd0);
    @(negedge clk);
    chk("ill.wb3", 32'(wb_valid), 32'd0);
    ld_valid = 1'b1;
    ld_addr = 3'd1;
    ld_data = 32'd7;
    instr_valid = 1'b1;
    instr_opcode = 4'd0;
    instr_rd = 3'd3;
    instr_rs1 = 3'd1;
    instr_rs2 = 3'd2;
    chk("rbw.ld_ready", 32'(ld_ready), 32'd1);
    @(negedge clk);
    ld_valid = 1'b0;
    instr_valid = 1'b0;
    chk("rbw.op_a", alu_op_a, 32'd2);
    chk("rbw.op_b", alu_op_b, 32'd3);
    @(negedge clk);
    chk("ldwb.ld_ready", 32'(ld_ready), 32'd0);
    ld_valid = 1'b1;
    ld_addr = 3'd2;
    ld_data = 32'd9;
    @(negedge clk);
    chk("rbw.wb_data", wb_data, 32'd5);
    chk("ldwb.ld_ready_idle", 32'(ld_ready), 32'd1);
    @(negedge clk);
    ld_valid = 1'b0;
    issue(4'd0, 3'd6, 3'd1, 3'd2, 32'd7, 32'd9, 32'd16, "after_ld");
    instr_valid = 1'b1;
    instr_opcode = 4'd0;
    instr_rd = 3'd3;
    instr_rs1 = 3'd1;
    instr_rs2 = 3'd2;
    @(negedge clk);
    instr_valid = 1'b0;
    ld_valid = 1'b1;
    ld_addr = 3'd3;
    ld_data = 32'hAA;
    chk("ldexec.ld_ready", 32'(ld_ready), 32'd1);
    @(negedge clk);
    ld_valid = 1'b0;
    @(negedge clk);
    chk("ldexec.wb_data", wb_data, 32'd16);
    issue(4'd1, 3'd7, 3'd3, 3'd1, 32'd16, 32'd7, 32'd9, "ldexec_rb");
    instr_valid = 1'b1;
    instr_opcode = 4'd0;
    instr_rd = 3'd5;
    @(negedge clk);
    instr_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst.ready", 32'(instr_ready), 32'd0);
    chk("midrst.op_a", alu_op_a, 32'd0);
    chk("midrst.wb", 32'(wb_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst.wb_after", 32'(wb_valid), 32'd0);
    issue(4'd0, 3'd4, 3'd1, 3'd2, 32'd0, 32'd0, 32'd0, "rf_clr12");
    issue(4'd3, 3'd4, 3'd3, 3'd7, 32'd0, 32'd0, 32'd0, "rf_clr37");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
